vga_scan_pipeline: RTL and testbench
====================================

Name: vga_scan_pipeline

Overview:
- Drives the raster scan for the VGA output path.
- Generates the DrawX/DrawY pixel coordinates that feed the colour mapper.
- Accepts the mapper's RGB for those coordinates after a fixed external latency, delays sync/blank to match, and registers everything onto the VGA pins.
- Sits between the top level (pixel-clock enable, VGA connector) and color_mapper.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BACK, 48, horizontal back porch (ticks); H_TOTAL = sum = 800
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
- PIPE_DEPTH, 0, pixel ticks between DrawX/DrawY and the matching Color_* input; legal range 0..4

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-tick enable, one Clk cycle wide (25 MHz rate)
- Color_R  in  8  red from mapper for coordinates presented PIPE_DEPTH ticks earlier
- Color_G  in  8  green, same timing as Color_R
- Color_B  in  8  blue, same timing as Color_R
- DrawX  out  10  current horizontal count, driven directly from the counter register
- DrawY  out  10  current vertical count, driven directly from the counter register
- frame_start  out  1  high for the Clk cycle where pix_en=1 and hc=0, vc=0
- VGA_HS  out  1  horizontal sync, active low, registered
- VGA_VS  out  1  vertical sync, active low, registered
- VGA_BLANK_N  out  1  high during the visible region, registered
- VGA_SYNC_N  out  1  constant 0
- VGA_R  out  8  registered red
- VGA_G  out  8  registered green
- VGA_B  out  8  registered blue

Behaviour:
- Clock and reset: one clock domain (Clk). Reset_n is asynchronous and active-low.
- Reset values: hc=0, vc=0; every delay-line stage holds hs=1, vs=1, vis=0; VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, VGA_R/G/B=0.
  - Reset asserted mid-frame forces these values immediately, with no clock edge needed.
  - After release, counting restarts at (0,0) on the first pix_en.
- pix_en=0: every register holds, including counters, delay line and outputs.
- Counters, per pix_en:
  - hc increments; at H_TOTAL-1, hc wraps to 0 and vc increments.
  - At hc=H_TOTAL-1 and vc=V_TOTAL-1, both wrap to 0 on the same tick.
- Decoded from the current (hc, vc):
  - hs=0 iff H_VISIBLE+H_FRONT <= hc < H_VISIBLE+H_FRONT+H_SYNC (656..751).
  - vs=0 iff V_VISIBLE+V_FRONT <= vc < V_VISIBLE+V_FRONT+V_SYNC (490..491).
  - vis=1 iff hc<H_VISIBLE and vc<V_VISIBLE.
- Delay line: {hs, vs, vis} passes through PIPE_DEPTH stages, each advancing only on pix_en. With PIPE_DEPTH=0 the line is bypassed.
- Output stage, on pix_en:
  - VGA_HS, VGA_VS and VGA_BLANK_N load the delayed hs, vs and vis.
  - VGA_R/G/B load Color_R/G/B when delayed vis=1, else 0x00.
- Total latency from a counter value to the VGA pins is PIPE_DEPTH+1 pixel ticks, identical for sync, blank and colour.
- RGB is never nonzero while VGA_BLANK_N=0.
- Color_* inputs are sampled only on pix_en cycles; values on other cycles are ignored.
- No Clk-domain combinational path exists from Color_* to the VGA outputs.

Test Plan:
1. Reset mid-frame: run to hc=300, vc=200, then pull Reset_n low between edges -> outputs go immediately to HS=1, VS=1, BLANK_N=0, RGB=0, DrawX=DrawY=0. Release with pix_en on alternate cycles -> DrawX steps 0,1,2,3 on successive ticks.
2. Horizontal timing, defaults: VGA_HS low for exactly 96 ticks, with falling edges 800 ticks apart. The falling edge appears PIPE_DEPTH+1 ticks after DrawX=656. VGA_BLANK_N is high for 640 ticks per visible line.
3. Vertical timing: VGA_VS low for exactly 1600 ticks; frame period 420000 ticks; frame_start pulses exactly once per frame and aligns with DrawX=0, DrawY=0.
4. Alignment, PIPE_DEPTH=2: the bench mapper drives Color_R = DrawX[7:0] delayed by 2 ticks -> on each visible tick VGA_R equals the low byte of the pixel's hc. Pixel 639 gives 0x7F; pixel 640 gives 0x00 with BLANK_N=0.
5. Blanking: Color_R/G/B held at 0xFF -> RGB is 0xFF exactly when BLANK_N=1 and 0x00 otherwise; exactly 307200 lit pixels per frame.
6. Stall: hold pix_en low for 10 Clk cycles at DrawX=100 -> DrawX, all VGA outputs and frame_start stay frozen, then counting resumes at 101.

Source files
------------

// File: rtl/vga_scan_pipeline_if.sv
// Bus between the scan pipeline, the colour mapper and the VGA connector.
//   master : the scan pipeline (drives coordinates and VGA pins, takes pix_en and mapper RGB)
//   slave  : the surrounding top level / mapper (drives pix_en and RGB, observes the rest)
// Signals:
//   pix_en              pixel-tick enable, one Clk cycle wide
//   Color_R/G/B         mapper RGB for the coordinates presented PIPE_DEPTH ticks earlier
//   DrawX/DrawY         current scan coordinates
//   frame_start         pix_en cycle at coordinate (0,0)
//   VGA_HS/VS/BLANK_N   registered sync and blank
//   VGA_SYNC_N          tied low
//   VGA_R/G/B           registered colour
interface vga_scan_pipeline_if;
   localparam int unsigned CW = 10;
   localparam int unsigned PW = 8;

   logic          pix_en;
   logic [PW-1:0] Color_R;
   logic [PW-1:0] Color_G;
   logic [PW-1:0] Color_B;
   logic [CW-1:0] DrawX;
   logic [CW-1:0] DrawY;
   logic          frame_start;
   logic          VGA_HS;
   logic          VGA_VS;
   logic          VGA_BLANK_N;
   logic          VGA_SYNC_N;
   logic [PW-1:0] VGA_R;
   logic [PW-1:0] VGA_G;
   logic [PW-1:0] VGA_B;

   modport master (
      input  pix_en, Color_R, Color_G, Color_B,
      output DrawX, DrawY, frame_start,
             VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
   );

   modport slave (
      output pix_en, Color_R, Color_G, Color_B,
      input  DrawX, DrawY, frame_start,
             VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R, VGA_G, VGA_B
   );
endinterface

// File: rtl/vga_scan_pipeline.sv
// VGA raster scan generator with a sync/blank delay line matched to the
// external colour-mapper latency, and a registered output stage.
// Ports:
//   Clk      system clock
//   Reset_n  asynchronous active-low reset
//   bus      vga_scan_pipeline_if.master (pix_en, mapper RGB in; coordinates,
//            frame_start and VGA pins out)
module vga_scan_pipeline #(
   parameter int unsigned H_VISIBLE  = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_BACK     = 48,
   parameter int unsigned V_VISIBLE  = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_BACK     = 33,
   parameter int unsigned PIPE_DEPTH = 0
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   vga_scan_pipeline_if.master  bus
);
   localparam int unsigned CW      = 10;
   localparam int unsigned PW      = 8;
   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
   localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FRONT);
   localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FRONT);
   localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

   // Delay-line word is {hs, vs, vis}; idle value is syncs inactive, blanked.
   localparam logic [2:0] IDLE_BITS = 3'b110;

   logic [CW-1:0] hc;
   logic [CW-1:0] vc;
   logic [2:0]    cur_c;
   logic [2:0]    dly_c;

   // Raster counters; vc advances on the hc wrap.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hc <= '0;
         vc <= '0;
      end else if (bus.pix_en) begin
         if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? '0 : vc + CW'(1);
         end else begin
            hc <= hc + CW'(1);
         end
      end
   end

   // Sync/blank decode of the current counter value.
   always_comb begin
      cur_c    = IDLE_BITS;
      cur_c[2] = !((hc >= HS_START) && (hc < HS_END));
      cur_c[1] = !((vc >= VS_START) && (vc < VS_END));
      cur_c[0] = (hc < H_VIS) && (vc < V_VIS);
   end

   // Delay line aligning sync/blank with the mapper's RGB latency.
   generate
      if (PIPE_DEPTH == 0) begin : g_bypass
         assign dly_c = cur_c;
      end else begin : g_line
         localparam int unsigned LW = 3 * PIPE_DEPTH;
         logic [LW-1:0] line_q;

         always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
               line_q <= {PIPE_DEPTH{IDLE_BITS}};
            end else if (bus.pix_en) begin
               line_q <= (line_q << 3) | LW'(cur_c);
            end
         end

         assign dly_c = line_q[LW-1 -: 3];
      end
   endgenerate

   // Registered VGA pins; colour is forced to black outside the visible region.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bus.VGA_HS      <= 1'b1;
         bus.VGA_VS      <= 1'b1;
         bus.VGA_BLANK_N <= 1'b0;
         bus.VGA_R       <= '0;
         bus.VGA_G       <= '0;
         bus.VGA_B       <= '0;
      end else if (bus.pix_en) begin
         bus.VGA_HS      <= dly_c[2];
         bus.VGA_VS      <= dly_c[1];
         bus.VGA_BLANK_N <= dly_c[0];
         bus.VGA_R       <= dly_c[0] ? bus.Color_R : PW'(0);
         bus.VGA_G       <= dly_c[0] ? bus.Color_G : PW'(0);
         bus.VGA_B       <= dly_c[0] ? bus.Color_B : PW'(0);
      end
   end

   assign bus.DrawX       = hc;
   assign bus.DrawY       = vc;
   assign bus.frame_start = bus.pix_en && (hc == '0) && (vc == '0);
   assign bus.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_pipeline.sv
// Scoreboard bench for vga_scan_pipeline: horizontal timing at full size,
// vertical timing shortened so whole frames fit in a short run, PIPE_DEPTH=2.
module tb_vga_scan_pipeline;
   localparam int HV = 640, HF = 16, HSW = 96, HB = 48;
   localparam int VV = 6,   VF = 1,  VSW = 2,  VB = 2;
   localparam int P  = 2;
   localparam int HT = HV + HF + HSW + HB;
   localparam int VT = VV + VF + VSW + VB;
   localparam int FRAME = HT * VT;

   typedef struct {
      int         x;
      int         y;
      bit         fs;
      bit         hs;
      bit         vs;
      bit         bl;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } exp_t;

   logic clk;
   logic rst_n;

   vga_scan_pipeline_if bus ();

   vga_scan_pipeline #(
      .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HSW), .H_BACK (HB),
      .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VSW), .V_BACK (VB),
      .PIPE_DEPTH(P)
   ) dut (
      .Clk    (clk),
      .Reset_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state: ticks since reset and the last values loaded on the pins.
   int         k;
   bit         o_hs, o_vs, o_bl;
   logic [7:0] o_r, o_g, o_b;

   function automatic int hc_of(input int t);
      return t % HT;
   endfunction

   function automatic int vc_of(input int t);
      return (t / HT) % VT;
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      k    = 0;
      o_hs = 1'b1;
      o_vs = 1'b1;
      o_bl = 1'b0;
      o_r  = 8'h00;
      o_g  = 8'h00;
      o_b  = 8'h00;
   endtask

   task automatic push_exp(input bit en);
      exp_t e;
      e.x  = hc_of(k);
      e.y  = vc_of(k);
      e.fs = en && (k % FRAME == 0);
      e.hs = o_hs;
      e.vs = o_vs;
      e.bl = o_bl;
      e.r  = o_r;
      e.g  = o_g;
      e.b  = o_b;
      q.push_back(e);
   endtask

   // Pull reset low between edges; the pins must change without a clock edge.
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n      = 1'b0;
      bus.pix_en = 1'b0;
      model_reset();
      push_exp(1'b0);
   endtask

   // One Clk cycle of stimulus; the mapper role returns hc[7:0] of the
   // pixel presented P ticks earlier on red, random green/blue.
   task automatic drive(input bit en, input bit white);
      logic [7:0] cr, cg, cb;
      int j, h, v;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cr = 8'($urandom);
      cg = 8'($urandom);
      cb = 8'($urandom);
      if (en) begin
         if (white) begin
            cr = 8'hFF;
            cg = 8'hFF;
            cb = 8'hFF;
         end else if (k >= P) begin
            cr = 8'(hc_of(k - P));
         end
      end
      bus.pix_en  = en;
      bus.Color_R = cr;
      bus.Color_G = cg;
      bus.Color_B = cb;
      push_exp(en);
      if (en) begin
         j = k - P;
         if (j >= 0) begin
            h    = hc_of(j);
            v    = vc_of(j);
            o_hs = !((h >= HV + HF) && (h < HV + HF + HSW));
            o_vs = !((v >= VV + VF) && (v < VV + VF + VSW));
            o_bl = (h < HV) && (v < VV);
            o_r  = o_bl ? cr : 8'h00;
            o_g  = o_bl ? cg : 8'h00;
            o_b  = o_bl ? cb : 8'h00;
         end
         k++;
      end
   endtask

   task automatic run_random_until(input int target);
      for (int i = 0; i < 60000 && k < target; i++) begin
         drive($urandom_range(0, 2) != 0, 1'b0);
      end
   endtask

   // Monitor: per-cycle scoreboard compare plus run-length timing checks.
   int hs_run, vs_run, tick_cnt, last_fs, last_fall;
   bit prev_en, have_fs, have_fall, prev_hs;

   initial begin
      exp_t e;
      hs_run = 0; vs_run = 0; tick_cnt = 0; last_fs = 0; last_fall = 0;
      prev_en = 1'b0; have_fs = 1'b0; have_fall = 1'b0; prev_hs = 1'b1;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("DrawX",       int'(bus.DrawX),       e.x);
            chk("DrawY",       int'(bus.DrawY),       e.y);
            chk("frame_start", int'(bus.frame_start), int'(e.fs));
            chk("VGA_HS",      int'(bus.VGA_HS),      int'(e.hs));
            chk("VGA_VS",      int'(bus.VGA_VS),      int'(e.vs));
            chk("VGA_BLANK_N", int'(bus.VGA_BLANK_N), int'(e.bl));
            chk("VGA_R",       int'(bus.VGA_R),       int'(e.r));
            chk("VGA_G",       int'(bus.VGA_G),       int'(e.g));
            chk("VGA_B",       int'(bus.VGA_B),       int'(e.b));
            chk("VGA_SYNC_N",  int'(bus.VGA_SYNC_N),  0);
         end
         if (!rst_n) begin
            hs_run = 0; vs_run = 0; tick_cnt = 0;
            prev_en = 1'b0; have_fs = 1'b0; have_fall = 1'b0; prev_hs = 1'b1;
         end else begin
            if (prev_en) begin
               tick_cnt++;
               if (!bus.VGA_HS) begin
                  if (prev_hs) begin
                     if (have_fall) chk("hs_fall_period", tick_cnt - last_fall, HT);
                     have_fall = 1'b1;
                     last_fall = tick_cnt;
                  end
                  hs_run++;
               end else if (hs_run != 0) begin
                  chk("hs_low_ticks", hs_run, HSW);
                  hs_run = 0;
               end
               if (!bus.VGA_VS) begin
                  vs_run++;
               end else if (vs_run != 0) begin
                  chk("vs_low_ticks", vs_run, VSW * HT);
                  vs_run = 0;
               end
               prev_hs = bus.VGA_HS;
            end
            if (bus.frame_start) begin
               if (have_fs) chk("frame_period", tick_cnt - last_fs, FRAME);
               have_fs = 1'b1;
               last_fs = tick_cnt;
            end
            prev_en = bus.pix_en;
         end
      end
   end

   initial begin
      rst_n       = 1'b0;
      bus.pix_en  = 1'b0;
      bus.Color_R = 8'h00;
      bus.Color_G = 8'h00;
      bus.Color_B = 8'h00;
      model_reset();

      do_reset();
      drive(1'b0, 1'b0);

      // Run to (300, 3) and reset mid-frame.
      run_random_until(3 * HT + 300);
      do_reset();

      // Release with pix_en on alternate cycles.
      drive(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0);
         drive(1'b0, 1'b0);
      end

      // Random pacing through a full frame, with a stall at DrawX=100 on line 2.
      run_random_until(2 * HT + 100);
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b0);
      run_random_until(FRAME + 500);

      // White mapper, continuous ticks through one more full frame.
      for (int i = 0; i < 30000 && k < 2 * FRAME + 900; i++) drive(1'b1, 1'b1);

      drive(1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("scoreboard_drained", q.size(), 0);
      chk("ticks_issued", (k >= 2 * FRAME + 900) ? 1 : 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
